cdc_sync_filter_array: RTL

CDC_SYNC_FILTER_ARRAY -- requirements
Module: cdc_sync_filter_array

---
 rtl/cdc_sync_pkg.sv | 14 +
 rtl/cdc_sync_filter_ch.sv | 61 ++++++
 rtl/cdc_sync_filter_array.sv | 48 ++++
 3 files changed

// File: rtl/cdc_sync_pkg.sv
// rtl/cdc_sync_pkg.sv - parameter limits and counter sizing for the synchroniser/filter array
package cdc_sync_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MIN_STAGES = 2;
    localparam int MAX_STAGES = 8;
    localparam int MAX_FILTER = 255;

    // Stability counter must be able to hold FILTER_CNT; never narrower than one bit.
    function automatic int cnt_width(input int filter_cnt);
        return (filter_cnt < 1) ? 1 : $clog2(filter_cnt + 1);
    endfunction

endpackage

// File: rtl/cdc_sync_filter_ch.sv
// rtl/cdc_sync_filter_ch.sv - one channel: flop-chain synchroniser, stability filter, edge pulses, sticky event
module cdc_sync_filter_ch
    import cdc_sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_CNT = 0,
    parameter logic RESET_BIT  = 1'b0
) (
    input  logic dest_clk,
    input  logic rst_n,
    input  logic src_in,
    input  logic evt_clr,
    output logic dest_out,
    output logic dest_rise,
    output logic dest_fall,
    output logic sticky_evt
);

    localparam int             CW      = cnt_width(FILTER_CNT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CNT);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          take;

    assign sync = sync_q[STAGES-1];
    // The new level is accepted once it has been seen differing for FILTER_CNT+1 edges.
    assign take = (sync != dest_out) && (cnt == CNT_MAX);

    always_ff @(posedge dest_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], src_in};
        end
    end

    always_ff @(posedge dest_clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_out   <= RESET_BIT;
            cnt        <= '0;
            dest_rise  <= 1'b0;
            dest_fall  <= 1'b0;
            sticky_evt <= 1'b0;
        end else begin
            if (sync == dest_out) begin
                cnt <= '0;
            end else if (take) begin
                dest_out <= sync;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            dest_rise  <= take & sync;
            dest_fall  <= take & ~sync;
            sticky_evt <= take | (sticky_evt & ~evt_clr);
        end
    end

endmodule

// File: rtl/cdc_sync_filter_array.sv
// rtl/cdc_sync_filter_array.sv - WIDTH independent synchronise-and-filter channels for async level inputs
module cdc_sync_filter_array
    import cdc_sync_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               STAGES     = 2,
    parameter int               FILTER_CNT = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             dest_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src_in,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] dest_out,
    output logic [WIDTH-1:0] dest_rise,
    output logic [WIDTH-1:0] dest_fall,
    output logic [WIDTH-1:0] sticky_evt
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("cdc_sync_filter_array: WIDTH %0d out of range", WIDTH);
    end
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("cdc_sync_filter_array: STAGES %0d out of range", STAGES);
    end
    if (FILTER_CNT < 0 || FILTER_CNT > MAX_FILTER) begin : g_bad_filter
        $error("cdc_sync_filter_array: FILTER_CNT %0d out of range", FILTER_CNT);
    end

    // Channels are unrelated; no attempt is made to keep bits of a bus coherent.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        cdc_sync_filter_ch #(
            .STAGES     (STAGES),
            .FILTER_CNT (FILTER_CNT),
            .RESET_BIT  (RESET_VAL[i])
        ) u_ch (
            .dest_clk   (dest_clk),
            .rst_n      (rst_n),
            .src_in     (src_in[i]),
            .evt_clr    (evt_clr[i]),
            .dest_out   (dest_out[i]),
            .dest_rise  (dest_rise[i]),
            .dest_fall  (dest_fall[i]),
            .sticky_evt (sticky_evt[i])
        );
    end

endmodule
